// File: rtl/clock_monitor_pkg.sv
// Shared types and helpers for the clock monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  // True when a measured half-period lies within exp_half +/- tol.
  function automatic logic in_tol(input logic [31:0] val,
                                  input logic [31:0] exp_half,
                                  input logic [31:0] tol);
    return ((val + tol) >= exp_half) && (val <= (exp_half + tol));
  endfunction

endpackage

// File: rtl/clock_monitor_sync.sv
// Two-flop synchronizer for the monitored pin plus rise/fall edge pulses.
module mon_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic mon_in,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= mon_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/clock_monitor.sv
// Measures high/low half-periods of mon_in in clk cycles, flags bad/stuck periods, reports lock.
// Optional macro CLOCK_MONITOR_STICKY_EN: err holds until clr_err instead of pulsing.
//
// state     | meaning
// IDLE      | monitor disabled
// WAIT_EDGE | waiting for a rising edge to start a period
// MEAS_HIGH | counting the high half, ends on falling edge
// MEAS_LOW  | counting the low half, rising edge completes the pair
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int EXP_HALF = 5,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(EXP_HALF + TOL + 1);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);

  state_t           state, state_nx;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  logic             cap_high, pair_done, pair_good, tmo, err_ev;

  mon_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .mon_in (mon_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // An edge arriving on the threshold cycle takes precedence over the timeout.
  always_comb begin
    state_nx  = state;
    cap_high  = 1'b0;
    pair_done = 1'b0;
    tmo       = 1'b0;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:      state_nx = WAIT_EDGE;
        WAIT_EDGE: if (rise) state_nx = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall) begin
            cap_high = 1'b1;
            state_nx = MEAS_LOW;
          end else if (!rise && cnt == TMO) begin
            tmo      = 1'b1;
            state_nx = WAIT_EDGE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            pair_done = 1'b1;
            state_nx  = MEAS_HIGH;
          end else if (!fall && cnt == TMO) begin
            tmo      = 1'b1;
            state_nx = WAIT_EDGE;
          end
        end
        default:   state_nx = IDLE;
      endcase
    end
  end

  assign pair_good = in_tol(32'(high_cnt), 32'(EXP_HALF), 32'(TOL)) &&
                     in_tol(32'(cnt), 32'(EXP_HALF), 32'(TOL));
  assign err_ev    = tmo | (pair_done & ~pair_good);

  always_ff @(posedge clk) begin
    if (!rst_n)             cnt <= '0;
    else if (rise | fall)   cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      low_cnt    <= '0;
      meas_valid <= 1'b0;
      good_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= pair_done;
      if (cap_high)  high_cnt <= cnt;
      if (pair_done) low_cnt  <= cnt;
      if (!en || err_ev) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (pair_done) begin
        if (good_cnt != GOOD_MAX)           good_cnt <= good_cnt + GW'(1);
        if (good_cnt >= GOOD_MAX - GW'(1))  locked   <= 1'b1;
      end
    end
  end

`ifdef CLOCK_MONITOR_STICKY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_ev)  err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;

  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_ev;
  end
`endif

endmodule
